// File: rtl/mem_arbiter_if.sv
// Port bundle for mem_arbiter: fetch and data request channels plus the shared memory bus.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic              if_err;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [1:0]        d_size;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic              d_err;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_rdata,
    output if_ack, if_err, if_rdata, d_ack, d_err, d_rdata,
           mem_en, mem_we, mem_size, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_rdata,
    input  if_ack, if_err, if_rdata, d_ack, d_err, d_rdata,
           mem_en, mem_we, mem_size, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency single-port memory between fetch and data stages.
// Data has priority; each access runs IDLE -> ISSUE -> WAIT -> RESP, misaligned ones skip to RESP.
module mem_arbiter #(
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              own_d_q, own_d_d;
  logic              we_q, we_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [1:0]        mem_size_q, mem_size_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_ack_q, if_ack_d;
  logic              if_err_q, if_err_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              d_ack_q, d_ack_d;
  logic              d_err_q, d_err_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return lsb[0];
      2'b10:   return lsb != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    own_d_d     = own_d_q;
    we_d        = we_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_size_d  = mem_size_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    if_err_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_ack_d     = 1'b0;
    d_err_d     = 1'b0;
    d_rdata_d   = d_rdata_q;

    case (state_q)
      IDLE: begin
        if (bus.d_req) begin
          own_d_d     = 1'b1;
          we_d        = bus.d_we;
          mem_size_d  = bus.d_size;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
          if (misaligned(bus.d_size, bus.d_addr[1:0])) begin
            state_d = RESP;
            d_ack_d = 1'b1;
            d_err_d = 1'b1;
          end else begin
            state_d  = ISSUE;
            mem_en_d = 1'b1;
            mem_we_d = bus.d_we;
          end
        end else if (bus.if_req) begin
          own_d_d     = 1'b0;
          we_d        = 1'b0;
          mem_size_d  = 2'b10;
          mem_addr_d  = bus.if_addr;
          mem_wdata_d = '0;
          if (bus.if_addr[1:0] != 2'b00) begin
            state_d  = RESP;
            if_ack_d = 1'b1;
            if_err_d = 1'b1;
          end else begin
            state_d  = ISSUE;
            mem_en_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        cnt_d   = 4'(MEM_LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        // Outputs are registered, so the ack is raised on the way into RESP.
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          if (own_d_q) begin
            d_rdata_d = bus.mem_rdata;
            d_ack_d   = 1'b1;
          end else begin
            if_rdata_d = bus.mem_rdata;
            if_ack_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      own_d_q     <= 1'b0;
      we_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_size_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_ack_q     <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      own_d_q     <= own_d_d;
      we_q        <= we_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_size_q  <= mem_size_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      if_err_q    <= if_err_d;
      if_rdata_q  <= if_rdata_d;
      d_ack_q     <= d_ack_d;
      d_err_q     <= d_err_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_size  = mem_size_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.if_err    = if_err_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.d_err     = d_err_q;
  assign bus.d_rdata   = d_rdata_q;

endmodule
